ctrl_sid_router: RTL and testbench

CTRL_SID_ROUTER -- requirements
Module: ctrl_sid_router

---
 rtl/ctrl_route_pkg.sv | 28 ++
 rtl/sid_route_lookup.sv | 38 +++
 rtl/ctrl_sid_router.sv | 125 ++++++++++++
 tb/tb_ctrl_sid_router.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_route_pkg.sv
// Shared definitions for the SID router: FSM states, route-entry layout and
// the settings-bus address map of the route table.
package ctrl_route_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } route_state_t;

    // Route-entry field positions inside set_data.
    localparam int ENTRY_SID_LSB = 0;
    localparam int ENTRY_SID_MSB = 7;
    localparam int ENTRY_EN_BIT  = 8;

    localparam logic [7:0] SR_BASE_DEFAULT = 8'd64;

    typedef struct packed {
        logic       en;
        logic [7:0] sid;
    } route_entry_t;

    // Settings address of route entry k.
    function automatic logic [7:0] sr_entry_addr(input logic [7:0] base, input int k);
        return base + k[7:0];
    endfunction

endpackage

// File: rtl/sid_route_lookup.sv
// Combinational priority match of a header SID against the route table;
// the lowest-numbered enabled matching entry wins.
module sid_route_lookup
    import ctrl_route_pkg::*;
#(
    parameter int         NUM_OUT  = 4,
    parameter logic [7:0] SID_MASK = 8'hF0
) (
    input  logic [7:0]                   sid,
    input  route_entry_t [NUM_OUT-1:0]   entries,
    output logic                         hit,
    output logic [$clog2(NUM_OUT)-1:0]   idx
);

    localparam int IDX_W = $clog2(NUM_OUT);

    logic [NUM_OUT-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_match
            assign match[gi] = entries[gi].en &&
                               ((sid & SID_MASK) == (entries[gi].sid & SID_MASK));
        end
    endgenerate

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_OUT - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit = 1'b1;
                idx = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ctrl_sid_router.sv
// Routes AXI-stream packets to one of NUM_OUT ports by the masked SID in the
// header beat; packets with no enabled matching route entry are dropped and counted.
module ctrl_sid_router
    import ctrl_route_pkg::*;
#(
    parameter int         WIDTH    = 64,
    parameter int         NUM_OUT  = 4,
    parameter logic [7:0] SR_BASE  = SR_BASE_DEFAULT,
    parameter logic [7:0] SID_MASK = 8'hF0
) (
    input  logic                       bus_clk,
    input  logic                       bus_rst_n,
    input  logic                       clear,
    input  logic                       set_stb,
    input  logic [7:0]                 set_addr,
    input  logic [31:0]                set_data,
    input  logic [WIDTH-1:0]           i_tdata,
    input  logic                       i_tlast,
    input  logic                       i_tvalid,
    output logic                       i_tready,
    output logic [NUM_OUT*WIDTH-1:0]   o_tdata,
    output logic [NUM_OUT-1:0]         o_tlast,
    output logic [NUM_OUT-1:0]         o_tvalid,
    input  logic [NUM_OUT-1:0]         o_tready,
    output logic [31:0]                drop_count,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_OUT);

    route_state_t               state_reg, state_next;
    logic [IDX_W-1:0]           dest_reg;
    logic [31:0]                drop_count_reg;
    route_entry_t               entries_reg [NUM_OUT];
    route_entry_t [NUM_OUT-1:0] entries_flat;
    logic                       hit;
    logic [IDX_W-1:0]           hit_idx;
    logic                       decide;
    logic                       unused_set_bits;

    assign unused_set_bits = ^set_data[31:ENTRY_EN_BIT+1];

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_entry
            always_ff @(posedge bus_clk or negedge bus_rst_n) begin
                if (!bus_rst_n) begin
                    entries_reg[gi] <= '0;
                end else if (set_stb && (set_addr == sr_entry_addr(SR_BASE, gi))) begin
                    entries_reg[gi].sid <= set_data[ENTRY_SID_MSB:ENTRY_SID_LSB];
                    entries_reg[gi].en  <= set_data[ENTRY_EN_BIT];
                end
            end
            assign entries_flat[gi] = entries_reg[gi];
        end
    endgenerate

    // Lookup sees the registered table, so a same-cycle write only affects later headers.
    sid_route_lookup #(
        .NUM_OUT  (NUM_OUT),
        .SID_MASK (SID_MASK)
    ) u_lookup (
        .sid     (i_tdata[7:0]),
        .entries (entries_flat),
        .hit     (hit),
        .idx     (hit_idx)
    );

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state_reg      <= ST_IDLE;
            dest_reg       <= '0;
            drop_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (decide) begin
                dest_reg <= hit_idx;
            end
            if (decide && !hit && (drop_count_reg != 32'hFFFF_FFFF)) begin
                drop_count_reg <= drop_count_reg + 32'd1;
            end
        end
    end

    // clear takes priority over everything and accepts no beat in its cycle.
    always_comb begin
        state_next = state_reg;
        i_tready   = 1'b0;
        o_tvalid   = '0;
        decide     = 1'b0;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_tvalid) begin
                        decide     = 1'b1;
                        state_next = hit ? ST_PASS : ST_DROP;
                    end
                end
                ST_PASS: begin
                    i_tready           = o_tready[dest_reg];
                    o_tvalid[dest_reg] = i_tvalid;
                    if (i_tvalid && o_tready[dest_reg] && i_tlast) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    i_tready = 1'b1;
                    if (i_tvalid && i_tlast) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign o_tdata    = {NUM_OUT{i_tdata}};
    assign o_tlast    = {NUM_OUT{i_tlast}};
    assign drop_count = drop_count_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ctrl_sid_router.sv
// Self-checking bench for ctrl_sid_router: directed vector table, hand-written
// corner sequences and randomized packets checked against a packet-level model.
module tb_ctrl_sid_router;

    localparam int W = 64;
    localparam int N = 4;

    logic             bus_clk = 1'b0;
    logic             bus_rst_n;
    logic             clear;
    logic             set_stb;
    logic [7:0]       set_addr;
    logic [31:0]      set_data;
    logic [W-1:0]     i_tdata;
    logic             i_tlast;
    logic             i_tvalid;
    logic             i_tready;
    logic [N*W-1:0]   o_tdata;
    logic [N-1:0]     o_tlast;
    logic [N-1:0]     o_tvalid;
    logic [N-1:0]     o_tready;
    logic [31:0]      drop_count;
    logic             busy;

    ctrl_sid_router #(
        .WIDTH    (W),
        .NUM_OUT  (N),
        .SR_BASE  (8'd64),
        .SID_MASK (8'hF0)
    ) dut (
        .bus_clk    (bus_clk),
        .bus_rst_n  (bus_rst_n),
        .clear      (clear),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .i_tdata    (i_tdata),
        .i_tlast    (i_tlast),
        .i_tvalid   (i_tvalid),
        .i_tready   (i_tready),
        .o_tdata    (o_tdata),
        .o_tlast    (o_tlast),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 bus_clk = ~bus_clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- output monitor ----------------
    typedef struct {
        int          port;
        logic [63:0] data;
        logic        last;
    } obeat_t;

    obeat_t got[$];
    int     got_rd  = 0;
    int     mon_err = 0;

    always @(negedge bus_clk) begin
        if (!$onehot0(o_tvalid)) mon_err++;
        for (int p = 0; p < N; p++) begin
            if (o_tvalid[p] && o_tready[p])
                got.push_back('{p, o_tdata[p*W +: W], o_tlast[p]});
        end
    end

    // ---------------- downstream ready driver ----------------
    logic         bp_en       = 1'b0;
    logic [N-1:0] ready_force = '1;

    initial begin
        o_tready = '1;
        forever begin
            @(posedge bus_clk);
            #2;
            o_tready = bp_en ? 4'($urandom) : ready_force;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0] m_sid [N];
    logic       m_en  [N];
    int         m_drops;

    function automatic int model_route(input logic [7:0] hdr);
        for (int k = 0; k < N; k++) begin
            if (m_en[k] && (((hdr ^ m_sid[k]) & 8'hF0) == 8'h00)) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_sid[k] = 8'h00;
            m_en[k]  = 1'b0;
        end
        m_drops = 0;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wr_raw(input logic [7:0] addr, input logic [31:0] data);
        set_stb  = 1'b1;
        set_addr = addr;
        set_data = data;
        @(posedge bus_clk);
        #1;
        set_stb = 1'b0;
    endtask

    task automatic wr_entry(input int k, input logic [8:0] v);
        wr_raw(8'd64 + k[7:0], {23'd0, v});
        m_sid[k] = v[7:0];
        m_en[k]  = v[8];
    endtask

    logic [63:0] sent_q[$];

    task automatic send_beat(input logic [63:0] d, input logic last, output int waited);
        i_tdata  = d;
        i_tlast  = last;
        i_tvalid = 1'b1;
        waited   = 0;
        while (1) begin
            @(negedge bus_clk);
            if (i_tready) break;
            waited++;
            if (waited > 300) begin
                checks++;
                failures++;
                $display("FAIL handshake_timeout actual=%0d required=<300", waited);
                break;
            end
        end
        @(posedge bus_clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] sid, input int n, output int hdr_wait);
        logic [63:0] d;
        int          w;
        sent_q.delete();
        hdr_wait = 0;
        for (int b = 0; b < n; b++) begin
            d = {$urandom, $urandom};
            if (b == 0) d[7:0] = sid;
            sent_q.push_back(d);
            send_beat(d, (b == n - 1), w);
            if (b == 0) hdr_wait = w;
        end
    endtask

    task automatic check_pkt(input string nm, input int exp_port, input int exp_drops);
        int avail;
        avail = got.size() - got_rd;
        if (exp_port < 0) begin
            chk({nm, "_no_out_beats"}, 64'(avail), 64'd0);
        end else begin
            chk({nm, "_beat_count"}, 64'(avail), 64'(sent_q.size()));
            for (int i = 0; i < sent_q.size(); i++) begin
                if (got_rd < got.size()) begin
                    chk({nm, "_port"}, 64'(got[got_rd].port), 64'(exp_port));
                    chk({nm, "_data"}, got[got_rd].data, sent_q[i]);
                    chk({nm, "_last"}, 64'(got[got_rd].last), 64'(i == sent_q.size() - 1));
                    got_rd++;
                end
            end
        end
        got_rd = got.size();
        chk({nm, "_drop_count"}, 64'(drop_count), 64'(exp_drops));
        $display("pkt %s sid=%02h beats=%0d port=%0d drop_count=%0d",
                 nm, sent_q[0][7:0], sent_q.size(), exp_port, drop_count);
    endtask

    task automatic do_reset();
        i_tvalid  = 1'b0;
        bus_rst_n = 1'b0;
        repeat (2) @(posedge bus_clk);
        #1;
        bus_rst_n = 1'b1;
        model_reset();
        got_rd = got.size();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [8:0] e0, e1, e2, e3;
        logic [7:0] sid;
        int         beats;
        int         port;
        int         drops;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int w;
        int exp;
        logic [7:0] sid;
        int n;

        vecs[0] = '{9'h110, 9'h140, 9'h000, 9'h000, 8'h12, 3,  0, 0};
        vecs[1] = '{9'h000, 9'h000, 9'h000, 9'h000, 8'h77, 2, -1, 1};
        vecs[2] = '{9'h140, 9'h000, 9'h140, 9'h000, 8'h45, 1,  0, 1};
        vecs[3] = '{9'h040, 9'h000, 9'h140, 9'h000, 8'h45, 2,  2, 1};
        vecs[4] = '{9'h000, 9'h000, 9'h000, 9'h1F3, 8'hF9, 4,  3, 1};
        vecs[5] = '{9'h120, 9'h130, 9'h000, 9'h000, 8'h3A, 1,  1, 1};
        vecs[6] = '{9'h120, 9'h000, 9'h000, 9'h000, 8'h10, 1, -1, 2};
        vecs[7] = '{9'h100, 9'h100, 9'h100, 9'h100, 8'h0F, 2,  0, 2};
        vecs[8] = '{9'h000, 9'h1A0, 9'h1A5, 9'h000, 8'hAC, 2,  1, 2};

        clear    = 1'b0;
        set_stb  = 1'b0;
        set_addr = 8'h00;
        set_data = 32'h0;
        i_tdata  = 64'h12;
        i_tlast  = 1'b0;
        i_tvalid = 1'b1;
        bus_rst_n = 1'b0;
        model_reset();

        // Reset state, with a header already waiting.
        @(posedge bus_clk);
        #1;
        chk("rst_i_tready", 64'(i_tready), 64'd0);
        chk("rst_o_tvalid", 64'(o_tvalid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        i_tvalid = 1'b0;
        @(posedge bus_clk);
        #1;
        bus_rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            wr_entry(0, vecs[i].e0);
            wr_entry(1, vecs[i].e1);
            wr_entry(2, vecs[i].e2);
            wr_entry(3, vecs[i].e3);
            wr_raw(8'd68, 32'h0000_01AA);
            wr_raw(8'd63, 32'h0000_01AA);
            send_pkt(vecs[i].sid, vecs[i].beats, w);
            chk($sformatf("vec%0d_bubble", i), 64'(w), 64'd1);
            check_pkt($sformatf("vec%0d", i), vecs[i].port, vecs[i].drops);
        end
        m_drops = 2;

        // Stall on port 1 for five cycles mid-packet.
        wr_entry(0, 9'h110);
        wr_entry(1, 9'h140);
        wr_entry(2, 9'h000);
        wr_entry(3, 9'h000);
        fork
            send_pkt(8'h45, 6, w);
            begin
                for (int c = 0; c < 100 && got.size() < got_rd + 2; c++) @(negedge bus_clk);
                @(posedge bus_clk);
                #1;
                ready_force = 4'b1101;
                repeat (5) begin
                    @(negedge bus_clk);
                    chk("stall_i_tready", 64'(i_tready), 64'd0);
                    chk("stall_o_tvalid", 64'(o_tvalid), 64'b0010);
                end
                @(posedge bus_clk);
                #1;
                ready_force = 4'b1111;
            end
        join
        check_pkt("stall", 1, m_drops);

        // Table rewrite mid-packet only affects the next header.
        fork
            send_pkt(8'h12, 4, w);
            begin
                for (int c = 0; c < 100 && got.size() < got_rd + 1; c++) @(negedge bus_clk);
                @(posedge bus_clk);
                #1;
                wr_entry(0, 9'h010);
            end
        join
        check_pkt("midwrite_cur", 0, m_drops);
        send_pkt(8'h12, 2, w);
        m_drops++;
        check_pkt("midwrite_next", -1, m_drops);

        // Write and header decision in the same cycle: pre-write contents route.
        wr_entry(0, 9'h110);
        set_stb  = 1'b1;
        set_addr = 8'd64;
        set_data = 32'h0;
        fork
            send_pkt(8'h12, 1, w);
            begin
                @(posedge bus_clk);
                #1;
                set_stb  = 1'b0;
                m_en[0]  = 1'b0;
                m_sid[0] = 8'h00;
            end
        join
        check_pkt("samecyc_cur", 0, m_drops);
        send_pkt(8'h12, 1, w);
        m_drops++;
        check_pkt("samecyc_next", -1, m_drops);

        // clear mid-packet: no beat taken that cycle, table and counter kept.
        wr_entry(0, 9'h110);
        i_tdata       = {$urandom, $urandom};
        i_tdata[7:0]  = 8'h12;
        i_tlast       = 1'b0;
        i_tvalid      = 1'b1;
        @(negedge bus_clk);
        chk("clr_idle_i_tready", 64'(i_tready), 64'd0);
        @(posedge bus_clk);
        #1;
        @(negedge bus_clk);
        chk("clr_pass_i_tready", 64'(i_tready), 64'd1);
        chk("clr_pass_busy", 64'(busy), 64'd1);
        @(posedge bus_clk);
        #1;
        i_tdata = {$urandom, $urandom};
        clear   = 1'b1;
        @(negedge bus_clk);
        chk("clr_i_tready", 64'(i_tready), 64'd0);
        chk("clr_o_tvalid", 64'(o_tvalid), 64'd0);
        @(posedge bus_clk);
        #1;
        clear    = 1'b0;
        i_tvalid = 1'b0;
        @(negedge bus_clk);
        chk("clr_after_busy", 64'(busy), 64'd0);
        chk("clr_after_drop_count", 64'(drop_count), 64'(m_drops));
        chk("clr_beats_out", 64'(got.size() - got_rd), 64'd1);
        got_rd = got.size();
        @(posedge bus_clk);
        #1;
        send_pkt(8'h12, 2, w);
        check_pkt("clr_next", 0, m_drops);

        // Asynchronous reset in the middle of a PASS packet.
        i_tdata      = {$urandom, $urandom};
        i_tdata[7:0] = 8'h12;
        i_tlast      = 1'b0;
        i_tvalid     = 1'b1;
        @(posedge bus_clk);
        #1;
        @(negedge bus_clk);
        chk("rstmid_o_tvalid_before", 64'(o_tvalid), 64'b0001);
        #1;
        bus_rst_n = 1'b0;
        #1;
        chk("rstmid_o_tvalid", 64'(o_tvalid), 64'd0);
        chk("rstmid_i_tready", 64'(i_tready), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_drop_count", 64'(drop_count), 64'd0);
        i_tvalid = 1'b0;
        @(posedge bus_clk);
        #1;
        bus_rst_n = 1'b1;
        model_reset();
        got_rd = got.size();
        send_pkt(8'h12, 1, w);
        m_drops++;
        check_pkt("rstmid_next", -1, m_drops);

        // Randomized packets with random backpressure.
        bp_en = 1'b1;
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 2)) begin
                wr_entry($urandom_range(0, 3),
                         {1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 4'($urandom)});
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge bus_clk);
                #1;
            end
            sid = {4'($urandom_range(0, 5)), 4'($urandom)};
            n   = $urandom_range(1, 5);
            exp = model_route(sid);
            send_pkt(sid, n, w);
            if (exp < 0) m_drops++;
            check_pkt($sformatf("rand%0d", t), exp, m_drops);
        end
        bp_en = 1'b0;

        repeat (2) @(posedge bus_clk);
        chk("onehot_o_tvalid", 64'(mon_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
